// File: rtl/brq_fp_regfile_sb.sv
// brq FP register file with N read / M write ports and a busy scoreboard.
// Issue claims a destination register; any write to a register releases it.
// Optional macro BRQ_FP_RF_BYPASS_EN: write-through reads (wdata_i -> rdata_o).
module brq_fp_regfile_sb #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumWords  = 32,
   parameter int unsigned NumRead   = 3,
   parameter int unsigned NumWrite  = 2,
   parameter int unsigned AddrWidth = $clog2(NumWords)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumRead-1:0][AddrWidth-1:0]  raddr_i,
   output logic [NumRead-1:0][DataWidth-1:0]  rdata_o,
   output logic [NumRead-1:0]                 rbusy_o,
   input  logic [NumWrite-1:0][AddrWidth-1:0] waddr_i,
   input  logic [NumWrite-1:0][DataWidth-1:0] wdata_i,
   input  logic [NumWrite-1:0]                we_i,
   input  logic                               claim_valid_i,
   input  logic [AddrWidth-1:0]               claim_addr_i,
   output logic                               claim_ready_o,
   output logic [NumWords-1:0]                busy_o,
   output logic [$clog2(NumWords+1)-1:0]      pending_cnt_o
);

   localparam int unsigned CntWidth = $clog2(NumWords + 1);

   logic [NumWords-1:0][DataWidth-1:0] r_mem;
   logic [NumWords-1:0]                r_busy;
   logic [CntWidth-1:0]                r_cnt;

   logic [NumWords-1:0]                w_wr_hit;
   logic [NumWords-1:0][DataWidth-1:0] w_wr_data;
   logic [NumWords-1:0]                w_claim_sel;
   logic [NumWords-1:0]                w_claim_set;
   logic [NumWords-1:0]                w_busy_nxt;
   logic [NumWords-1:0]                w_clr;
   logic                               w_claim_ok;
   logic                               w_set_new;
   logic [CntWidth-1:0]                w_clr_cnt;
   logic [CntWidth-1:0]                w_cnt_nxt;

   // Per-word write decode; later ports override earlier ones, out-of-range never matches.
   always_comb begin
      w_wr_hit  = '0;
      w_wr_data = '0;
      for (int unsigned i = 0; i < NumWords; i++) begin
         for (int unsigned w = 0; w < NumWrite; w++) begin
            if (we_i[w] && (waddr_i[w] == AddrWidth'(i))) begin
               w_wr_hit[i]  = 1'b1;
               w_wr_data[i] = wdata_i[w];
            end
         end
      end
   end

   // Claim acceptance, next scoreboard and pending counter update.
   always_comb begin
      w_claim_sel = '0;
      for (int unsigned i = 0; i < NumWords; i++) begin
         w_claim_sel[i] = claim_valid_i && (claim_addr_i == AddrWidth'(i));
      end
      w_claim_ok  = |(w_claim_sel & (~r_busy | w_wr_hit));
      w_claim_set = w_claim_ok ? w_claim_sel : '0;
      w_busy_nxt  = (r_busy & ~w_wr_hit) | w_claim_set;
      w_set_new   = |(w_claim_set & ~r_busy);
      w_clr       = r_busy & w_wr_hit & ~w_claim_set;
      w_clr_cnt   = '0;
      for (int unsigned i = 0; i < NumWords; i++) begin
         w_clr_cnt = w_clr_cnt + CntWidth'(w_clr[i]);
      end
      w_cnt_nxt = r_cnt + CntWidth'(w_set_new) - w_clr_cnt;
   end

   assign claim_ready_o = w_claim_ok;
   assign busy_o        = r_busy;
   assign pending_cnt_o = r_cnt;

   // Combinational read ports; unmatched (out-of-range) addresses read 0 / not busy.
   always_comb begin
      rdata_o = '0;
      rbusy_o = '0;
      for (int unsigned k = 0; k < NumRead; k++) begin
         for (int unsigned i = 0; i < NumWords; i++) begin
            if (raddr_i[k] == AddrWidth'(i)) begin
               rdata_o[k] = r_mem[i];
               rbusy_o[k] = r_busy[i];
`ifdef BRQ_FP_RF_BYPASS_EN
               if (w_wr_hit[i]) begin
                  rdata_o[k] = w_wr_data[i];
                  rbusy_o[k] = w_claim_set[i];
               end
`endif
            end
         end
      end
   end

   // Register array, scoreboard and counter state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_mem  <= '0;
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         for (int unsigned i = 0; i < NumWords; i++) begin
            if (w_wr_hit[i]) begin
               r_mem[i] <= w_wr_data[i];
            end
         end
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_brq_fp_regfile_sb.sv
// Self-checking bench for brq_fp_regfile_sb: directed steps plus random traffic
// checked against an array-based model of register contents and busy flags.
module tb_brq_fp_regfile_sb;

   localparam int unsigned NW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n;
   logic [2:0][4:0]       raddr;
   logic [2:0][31:0]      rdata;
   logic [2:0]            rbusy;
   logic [1:0][4:0]       waddr;
   logic [1:0][31:0]      wdata;
   logic [1:0]            we;
   logic                  cv;
   logic [4:0]            ca;
   logic                  cr;
   logic [31:0]           busy;
   logic [5:0]            pcnt;

   logic [2:0][4:0]       raddr_b;
   logic [2:0][31:0]      rdata_b;
   logic [2:0]            rbusy_b;
   logic [1:0][4:0]       waddr_b;
   logic [1:0][31:0]      wdata_b;
   logic [1:0]            we_b;
   logic                  cv_b;
   logic [4:0]            ca_b;
   logic                  cr_b;
   logic [23:0]           busy_b;
   logic [4:0]            pcnt_b;

   brq_fp_regfile_sb u_dut (
      .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .claim_valid_i(cv), .claim_addr_i(ca),
      .claim_ready_o(cr), .busy_o(busy), .pending_cnt_o(pcnt)
   );

   brq_fp_regfile_sb #(.NumWords(24)) u_dut24 (
      .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr_b), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
      .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b), .claim_valid_i(cv_b), .claim_addr_i(ca_b),
      .claim_ready_o(cr_b), .busy_o(busy_b), .pending_cnt_o(pcnt_b)
   );

   // Reference model state
   logic [31:0] m_mem [NW];
   bit          m_busy [NW];
   bit          m_last_acc;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_release(input logic [4:0] a);
      for (int w = 0; w < 2; w++) if (we[w] && waddr[w] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      return cv && (int'(ca) < NW) && (!m_busy[ca] || m_release(ca));
   endfunction

   function automatic logic [31:0] m_rdata(input logic [4:0] a);
      logic [31:0] d;
      d = (int'(a) < NW) ? m_mem[a] : 32'h0;
`ifdef BRQ_FP_RF_BYPASS_EN
      for (int w = 0; w < 2; w++) if (we[w] && waddr[w] == a) d = wdata[w];
`endif
      return d;
   endfunction

   function automatic bit m_rbusy(input logic [4:0] a);
      if (int'(a) >= NW) return 1'b0;
`ifdef BRQ_FP_RF_BYPASS_EN
      if (m_release(a)) return m_ready() && (ca == a);
`endif
      return m_busy[a];
   endfunction

   function automatic logic [31:0] m_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < NW; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NW; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic m_edge();
      bit rdy;
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
         m_last_acc = 1'b0;
         return;
      end
      rdy = m_ready();
      for (int w = 0; w < 2; w++) begin
         if (we[w]) begin
            m_mem[waddr[w]]  = wdata[w];
            m_busy[waddr[w]] = 1'b0;
         end
      end
      if (rdy) m_busy[ca] = 1'b1;
      m_last_acc = rdy;
   endtask

   // One clock: check comb outputs at negedge, advance model, check registered outputs.
   task automatic tick();
      @(negedge clk);
      if (rst_n) begin
         chk("claim_ready", 64'(cr), 64'(m_ready()));
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdata%0d@%0d", k, raddr[k]), 64'(rdata[k]), 64'(m_rdata(raddr[k])));
            chk($sformatf("rbusy%0d@%0d", k, raddr[k]), 64'(rbusy[k]), 64'(m_rbusy(raddr[k])));
         end
      end
      @(posedge clk);
      m_edge();
      #1;
      chk("busy_o", 64'(busy), 64'(m_busy_vec()));
      chk("pending_cnt", 64'(pcnt), 64'(m_count()));
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      m_last_acc = 1'b0;
      rst_n = 1'b0; cv = 1'b0; ca = '0; raddr = '0;
      we = 2'b01; waddr = '0; waddr[0] = 5'd5; wdata = '0; wdata[0] = 32'h41a00000;
      cv_b = 1'b0; ca_b = '0; raddr_b = '0; we_b = '0; waddr_b = '0; wdata_b = '0;

      // Reset with a concurrent write that must be ignored
      tick(); tick();
      rst_n = 1'b1; we = '0;
      for (int b = 0; b < 33; b += 3) begin
         raddr[0] = 5'(b); raddr[1] = 5'(b + 1); raddr[2] = 5'(b + 2);
         tick();
      end
      raddr[0] = 5'd5; #2;
      chk("rst_reg5", 64'(rdata[0]), 64'h0);

      // Out-of-range behaviour on the 24-word instance
      cv_b = 1'b1; ca_b = 5'd30; we_b = 2'b01; waddr_b[0] = 5'd30; wdata_b[0] = 32'hdeadbeef;
      raddr_b[0] = 5'd30; raddr_b[1] = 5'd6; raddr_b[2] = 5'd23;
      @(negedge clk);
      chk("b_claim30_ready", 64'(cr_b), 64'h0);
      chk("b_rd30", 64'(rdata_b[0]), 64'h0);
      chk("b_rbusy30", 64'(rbusy_b[0]), 64'h0);
      @(posedge clk); #1;
      chk("b_busy_after30", 64'(busy_b), 64'h0);
      chk("b_cnt_after30", 64'(pcnt_b), 64'h0);
      chk("b_rd30_after", 64'(rdata_b[0]), 64'h0);
      chk("b_rd6_alias", 64'(rdata_b[1]), 64'h0);
      ca_b = 5'd23; we_b = '0; #2;
      chk("b_claim23_ready", 64'(cr_b), 64'h1);
      @(posedge clk); #1;
      cv_b = 1'b0;
      chk("b_busy23", 64'(busy_b), 64'h800000);
      chk("b_cnt23", 64'(pcnt_b), 64'h1);
      chk("b_rbusy23", 64'(rbusy_b[2]), 64'h1);
      chk("b_rbusy30_b", 64'(rbusy_b[0]), 64'h0);

      // Two ports write reg 5 in the same cycle: port 1 wins
      we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
      wdata[0] = 32'h41a00000; wdata[1] = 32'h41200000;
      tick();
      we = '0; raddr[0] = 5'd5; #2;
      chk("wr_priority", 64'(rdata[0]), 64'h41200000);
      tick();

      // Write-through (bypass) vs registered read of reg 3
      we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'hc0490fdb; raddr[1] = 5'd3; #2;
`ifdef BRQ_FP_RF_BYPASS_EN
      chk("rd3_same_cycle", 64'(rdata[1]), 64'hc0490fdb);
`else
      chk("rd3_same_cycle", 64'(rdata[1]), 64'h0);
`endif
      tick();
      we = '0; #2;
      chk("rd3_next_cycle", 64'(rdata[1]), 64'hc0490fdb);
      tick();

      // Claim reg 7, hold a second claim until a write releases it
      cv = 1'b1; ca = 5'd7; raddr[2] = 5'd7; #2;
      chk("claim7_ready", 64'(cr), 64'h1);
      tick();
      chk("claim7_busy", 64'(busy[7]), 64'h1);
      chk("claim7_cnt", 64'(pcnt), 64'h1);
      for (int c = 0; c < 3; c++) begin
         #2; chk($sformatf("claim7_blocked%0d", c), 64'(cr), 64'h0);
         tick();
      end
      we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h3f800000; #2;
      chk("claim7_release_ready", 64'(cr), 64'h1);
      tick();
      cv = 1'b0; we = '0; raddr[0] = 5'd7; #2;
      chk("claim7_data", 64'(rdata[0]), 64'h3f800000);
      chk("claim7_still_busy", 64'(busy[7]), 64'h1);
      chk("claim7_cnt_same", 64'(pcnt), 64'h1);

      // Release 7, then claim all registers back to back and release two per cycle
      we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h0;
      tick();
      we = '0; cv = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ca = 5'(i);
         tick();
      end
      cv = 1'b0;
      chk("cnt_full", 64'(pcnt), 64'd32);
      for (int i = 0; i < 16; i++) begin
         we = 2'b11; waddr[0] = 5'(2 * i); waddr[1] = 5'(2 * i + 1);
         wdata[0] = $urandom(); wdata[1] = $urandom();
         tick();
         chk($sformatf("cnt_drain%0d", i), 64'(pcnt), 64'(32 - 2 * (i + 1)));
      end
      we = '0;

      // Random traffic with a requester that holds a claim until it is accepted
      for (int c = 0; c < 400; c++) begin
         if (!cv || m_last_acc || !rst_n) begin
            cv = ($urandom_range(0, 2) != 0);
            ca = 5'($urandom_range(0, 31));
         end
         rst_n = ($urandom_range(0, 59) != 0);
         for (int w = 0; w < 2; w++) begin
            we[w]    = 1'($urandom_range(0, 1));
            waddr[w] = ($urandom_range(0, 3) == 0) ? ca : 5'($urandom_range(0, 31));
            wdata[w] = $urandom();
         end
         for (int k = 0; k < 3; k++) begin
            raddr[k] = ($urandom_range(0, 3) == 0) ? waddr[k % 2] : 5'($urandom_range(0, 31));
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
